mag_peak_detect: RTL and testbench

- Downstream consumer of the Sobel magnitude stage: takes the 8-bit normalised gradient magnitude stream in raster order and flags 3x3 local maxima above a threshold as particle-edge candidates.
- Holds two line buffers and a 3x3 window.
- Emits one peak record (x, y, magnitude) per detected maximum, a running peak count and an end-of-frame pulse for the particle-grouping stage.

---
 rtl/pd_pkg.sv | 38 +++
 rtl/mag_line_buffer.sv | 27 ++
 rtl/mag_peak_detect.sv | 173 +++++++++++++++++
 tb/tb_mag_peak_detect.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pd_pkg.sv
// Shared definitions for the peak-detect stage and the downstream particle-grouping stage.
// Holds the default geometry, the threshold, the peak record type and the 3x3 maximum test.
package pd_pkg;

  localparam int PD_IMG_W    = 512;
  localparam int PD_IMG_H    = 1024;
  localparam int PD_XW       = 9;
  localparam int PD_YW       = 10;
  localparam int PD_PEAK_THR = 32;
  localparam int PD_CNTW     = 16;
  localparam int PD_MAGW     = 8;

  typedef struct packed {
    logic [PD_XW-1:0]   x;
    logic [PD_YW-1:0]   y;
    logic [PD_MAGW-1:0] mag;
  } peak_rec_t;

  // Non-strict against the row above and the west neighbour, strict against the rest,
  // so that a flat plateau yields exactly one peak (its bottom-right member).
  function automatic logic pd_is_peak(
    input logic [PD_MAGW-1:0] c,
    input logic [PD_MAGW-1:0] nw,
    input logic [PD_MAGW-1:0] n,
    input logic [PD_MAGW-1:0] ne,
    input logic [PD_MAGW-1:0] w,
    input logic [PD_MAGW-1:0] e,
    input logic [PD_MAGW-1:0] sw,
    input logic [PD_MAGW-1:0] s,
    input logic [PD_MAGW-1:0] se,
    input logic [PD_MAGW-1:0] thr
  );
    return (c >= thr) &&
           (c >= nw) && (c >= n) && (c >= ne) && (c >= w) &&
           (c >  e)  && (c >  sw) && (c > s) && (c > se);
  endfunction

endpackage

// File: rtl/mag_line_buffer.sv
// One line of magnitude history: block RAM with a registered read port and a write port.
// A read and a write to the same address in one cycle returns the old contents.
module mag_line_buffer
  import pd_pkg::*;
#(
  parameter int DEPTH = PD_IMG_W,
  parameter int AW    = PD_XW,
  parameter int DW    = PD_MAGW
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mag_peak_detect.sv
// 3x3 local-maximum detector on a raster stream of gradient magnitudes.
// Emits one (x, y, mag) record per peak, a per-frame peak count and an end-of-frame pulse.
module mag_peak_detect
  import pd_pkg::*;
#(
  parameter int IMG_W    = PD_IMG_W,
  parameter int IMG_H    = PD_IMG_H,
  parameter int XW       = PD_XW,
  parameter int YW       = PD_YW,
  parameter int PEAK_THR = PD_PEAK_THR,
  parameter int CNTW     = PD_CNTW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_start,
  input  logic            pix_valid,
  input  logic [7:0]      mag,
  output logic            peak_valid,
  output logic [XW-1:0]   peak_x,
  output logic [YW-1:0]   peak_y,
  output logic [7:0]      peak_mag,
  output logic [CNTW-1:0] peak_count,
  output logic            frame_done
);

  logic [XW-1:0]   x_reg;
  logic [YW-1:0]   y_reg;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  logic [XW-1:0]   x_next;
  logic [YW-1:0]   y_next;
  logic [XW-1:0]   rd_addr;
  logic            accept;
  logic            last_x;
  logic            last_y;
  logic            peak_hit;
  logic            last_pix;
  logic [7:0]      lb0_q;
  logic [7:0]      lb1_q;
  logic [7:0]      col_in   [3];
  logic [7:0]      win_reg  [3][3];
  logic [7:0]      win_next [3][3];

  logic            peak_valid_reg;
  logic [XW-1:0]   peak_x_reg;
  logic [YW-1:0]   peak_y_reg;
  logic [7:0]      peak_mag_reg;
  logic [CNTW-1:0] peak_count_reg;
  logic            frame_done_reg;

  // A frame_start in the same cycle as an accept makes that pixel (0,0).
  always_comb begin
    accept = pix_valid;
    cur_x  = frame_start ? '0 : x_reg;
    cur_y  = frame_start ? '0 : y_reg;
    last_x = (cur_x == XW'(IMG_W - 1));
    last_y = (cur_y == YW'(IMG_H - 1));
    x_next = last_x ? '0 : cur_x + 1'b1;
    y_next = cur_y;
    if (last_x) begin
      y_next = last_y ? '0 : cur_y + 1'b1;
    end
    // The RAM read is registered, so it is always aimed at the next pixel to be accepted.
    rd_addr = accept ? x_next : cur_x;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (accept) begin
      x_reg <= x_next;
      y_reg <= y_next;
    end else if (frame_start) begin
      x_reg <= '0;
      y_reg <= '0;
    end
  end

  // lb0 holds row y-1; its old contents cascade into lb1 as row y-2.
  mag_line_buffer #(
    .DEPTH (IMG_W),
    .AW    (XW),
    .DW    (8)
  ) u_lb0 (
    .clk     (clk),
    .rd_addr (rd_addr),
    .rd_data (lb0_q),
    .we      (accept),
    .wr_addr (cur_x),
    .wr_data (mag)
  );

  mag_line_buffer #(
    .DEPTH (IMG_W),
    .AW    (XW),
    .DW    (8)
  ) u_lb1 (
    .clk     (clk),
    .rd_addr (rd_addr),
    .rd_data (lb1_q),
    .we      (accept),
    .wr_addr (cur_x),
    .wr_data (lb0_q)
  );

  // Window rows: 0 = y-2, 1 = y-1, 2 = y; column 2 is the newest.
  always_comb begin
    col_in[0] = lb1_q;
    col_in[1] = lb0_q;
    col_in[2] = mag;
    for (int r = 0; r < 3; r++) begin
      win_next[r][0] = win_reg[r][1];
      win_next[r][1] = win_reg[r][2];
      win_next[r][2] = col_in[r];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_reg[r][c] <= '0;
        end
      end
    end else if (accept) begin
      win_reg <= win_next;
    end
  end

  // x >= 2 and y >= 2 keeps the centre off every border and off unwritten buffer rows.
  always_comb begin
    peak_hit = accept && (cur_x >= XW'(2)) && (cur_y >= YW'(2)) &&
               pd_is_peak(win_next[1][1],
                          win_next[0][0], win_next[0][1], win_next[0][2],
                          win_next[1][0], win_next[1][2],
                          win_next[2][0], win_next[2][1], win_next[2][2],
                          8'(PEAK_THR));
    last_pix = accept && last_x && last_y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_valid_reg <= 1'b0;
      peak_x_reg     <= '0;
      peak_y_reg     <= '0;
      peak_mag_reg   <= '0;
      peak_count_reg <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      peak_valid_reg <= peak_hit;
      frame_done_reg <= last_pix;
      if (peak_hit) begin
        peak_x_reg   <= cur_x - 1'b1;
        peak_y_reg   <= cur_y - 1'b1;
        peak_mag_reg <= win_next[1][1];
      end
      if (frame_start) begin
        peak_count_reg <= '0;
      end else if (peak_hit && !(&peak_count_reg)) begin
        peak_count_reg <= peak_count_reg + 1'b1;
      end
    end
  end

  assign peak_valid = peak_valid_reg;
  assign peak_x     = peak_x_reg;
  assign peak_y     = peak_y_reg;
  assign peak_mag   = peak_mag_reg;
  assign peak_count = peak_count_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_mag_peak_detect.sv
// Directed bench for mag_peak_detect on an 8x6 image with threshold 32.
// Each frame is driven from a small image table; peaks and frame_done are logged per accept.
module tb_mag_peak_detect;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int XW   = 3;
  localparam int YW   = 3;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            frame_start;
  logic            pix_valid;
  logic [7:0]      mag;
  logic            peak_valid;
  logic [XW-1:0]   peak_x;
  logic [YW-1:0]   peak_y;
  logic [7:0]      peak_mag;
  logic [CNTW-1:0] peak_count;
  logic            frame_done;

  always #5 clk = ~clk;

  mag_peak_detect #(
    .IMG_W    (W),
    .IMG_H    (H),
    .XW       (XW),
    .YW       (YW),
    .PEAK_THR (32),
    .CNTW     (CNTW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .mag         (mag),
    .peak_valid  (peak_valid),
    .peak_x      (peak_x),
    .peak_y      (peak_y),
    .peak_mag    (peak_mag),
    .peak_count  (peak_count),
    .frame_done  (frame_done)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] img [W*H];
  int acc, n_peaks, n_done, done_idx, pk_idx, pk_x, pk_y, pk_mag, stray;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < W*H; i++) img[i] = 8'd0;
  endtask

  task automatic put(input int x, input int y, input int v);
    img[y*W + x] = 8'(v);
  endtask

  task automatic clear_stats();
    n_peaks = 0; n_done = 0; done_idx = -1; pk_idx = -1;
    pk_x = -1; pk_y = -1; pk_mag = -1; stray = 0;
  endtask

  // One clock: drive, let the edge happen, then observe what that edge produced.
  task automatic step(input bit v, input bit fs, input logic [7:0] m);
    pix_valid   = v;
    frame_start = fs;
    mag         = m;
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    mag         = 8'd0;
    if (peak_valid) begin
      if (v) begin
        n_peaks++;
        pk_idx = acc; pk_x = int'(peak_x); pk_y = int'(peak_y); pk_mag = int'(peak_mag);
        $display("peak x=%0d y=%0d mag=%0d count=%0d after accept %0d",
                 pk_x, pk_y, pk_mag, int'(peak_count), acc);
      end else begin
        stray++;
      end
    end
    if (frame_done) begin
      if (v) begin
        n_done++;
        done_idx = acc;
      end else begin
        stray++;
      end
    end
    if (v) acc++;
  endtask

  // fs_mode: 0 = separate frame_start pulse, 1 = frame_start with first pixel, 2 = none
  task automatic run_frame(input int n_pix, input bit stall, input int fs_mode);
    acc = 0;
    if (fs_mode == 0) step(1'b0, 1'b1, 8'd0);
    for (int i = 0; i < n_pix; i++) begin
      step(1'b1, (fs_mode == 1) && (i == 0), img[i]);
      if (stall) step(1'b0, 1'b0, 8'd0);
    end
    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    $display("frame: pixels=%0d peaks=%0d done=%0d count=%0d", n_pix, n_peaks, n_done,
             int'(peak_count));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; mag = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(peak_valid), 0);
    check("rst_x",     int'(peak_x),     0);
    check("rst_y",     int'(peak_y),     0);
    check("rst_mag",   int'(peak_mag),   0);
    check("rst_count", int'(peak_count), 0);
    check("rst_done",  int'(frame_done), 0);
    reset = 1'b0;

    // single spike
    clear_img(); put(3, 2, 100); clear_stats();
    run_frame(W*H, 1'b0, 0);
    check("spike_n",     n_peaks, 1);
    check("spike_x",     pk_x, 3);
    check("spike_y",     pk_y, 2);
    check("spike_mag",   pk_mag, 100);
    check("spike_lat",   pk_idx, 28);
    check("spike_count", int'(peak_count), 1);
    check("spike_done",  done_idx, 47);
    check("spike_ndone", n_done, 1);
    check("spike_stray", stray, 0);
    check("spike_hold",  int'(peak_x), 3);

    // sub-threshold centre and bright border pixels
    clear_img(); put(3, 2, 31); put(0, 3, 200); put(7, 5, 200); clear_stats();
    run_frame(W*H, 1'b0, 0);
    check("sub_n",     n_peaks, 0);
    check("sub_count", int'(peak_count), 0);
    check("sub_done",  done_idx, 47);

    // 2x2 plateau, frame_start coincident with the first pixel
    clear_img(); put(2, 2, 80); put(3, 2, 80); put(2, 3, 80); put(3, 3, 80); clear_stats();
    run_frame(W*H, 1'b0, 1);
    check("plat_n",     n_peaks, 1);
    check("plat_x",     pk_x, 3);
    check("plat_y",     pk_y, 3);
    check("plat_mag",   pk_mag, 80);
    check("plat_lat",   pk_idx, 36);
    check("plat_count", int'(peak_count), 1);
    check("plat_done",  done_idx, 47);

    // spike frame with an idle cycle after every pixel
    clear_img(); put(3, 2, 100); clear_stats();
    run_frame(W*H, 1'b1, 0);
    check("stall_n",     n_peaks, 1);
    check("stall_x",     pk_x, 3);
    check("stall_y",     pk_y, 2);
    check("stall_mag",   pk_mag, 100);
    check("stall_lat",   pk_idx, 28);
    check("stall_done",  done_idx, 47);
    check("stall_stray", stray, 0);

    // abandoned frame after 20 pixels, then a full frame
    clear_img(); put(5, 4, 90); clear_stats();
    run_frame(20, 1'b0, 0);
    run_frame(W*H, 1'b0, 0);
    check("mid_n",     n_peaks, 1);
    check("mid_x",     pk_x, 5);
    check("mid_y",     pk_y, 4);
    check("mid_mag",   pk_mag, 90);
    check("mid_lat",   pk_idx, 46);
    check("mid_ndone", n_done, 1);
    check("mid_done",  done_idx, 47);
    check("mid_count", int'(peak_count), 1);

    // reset at pixel 30 with a spike still pending, reset together with frame_start
    clear_img(); put(4, 3, 150); clear_stats();
    run_frame(30, 1'b0, 0);
    check("pre_rst_n", n_peaks, 0);
    reset = 1'b1; frame_start = 1'b1; pix_valid = 1'b1; mag = 8'd200;
    @(posedge clk);
    #1;
    reset = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; mag = 8'd0;
    check("mrst_valid", int'(peak_valid), 0);
    check("mrst_x",     int'(peak_x),     0);
    check("mrst_y",     int'(peak_y),     0);
    check("mrst_mag",   int'(peak_mag),   0);
    check("mrst_count", int'(peak_count), 0);
    check("mrst_done",  int'(frame_done), 0);
    clear_img(); clear_stats();
    run_frame(W*H, 1'b0, 2);
    check("post_n",     n_peaks, 0);
    check("post_ndone", n_done, 1);
    check("post_done",  done_idx, 47);
    check("post_count", int'(peak_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
